avalon_wrr_arbiter: RTL and testbench
=====================================

AVALON_WRR_ARBITER -- requirements
Module: avalon_wrr_arbiter

Interface
REQ-001 Parameter NUM_MST, default 5: number of requesting masters.
REQ-002 Parameter SEL_W, default 3: width of the port-select code; SHALL satisfy 2**SEL_W >= NUM_MST.
REQ-003 Parameter QUANTUM, default 4: accepted transfers per ownership turn; legal range 1..15.
REQ-004 Parameter STARVE_LIMIT, default 64: wait-cycle threshold for starvation promotion; legal range 2..255.
REQ-005 clk  in  1  single clock; all state is updated on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_i  in  NUM_MST  per-master request, held high while that master drives RdEn or WrEn toward this slave.
REQ-008 slave_waitreq_i  in  1  slave WaitRequest; a transfer is accepted in any cycle with owner request high and this input low.
REQ-009 grant_o  out  NUM_MST  registered one-hot grant, or all zero.
REQ-010 port_sel_o  out  SEL_W  binary index of the granted master, or 0 when idle.
REQ-011 port_nosel_o  out  1  high when no master is granted.
REQ-012 xfer_cnt_o  out  4  accepted transfers in the current turn.
REQ-013 starve_o  out  1  one-cycle pulse when a starvation promotion is taken.

Function
REQ-014 The arbiter SHALL have two states: IDLE (no grant) and OWN (one master granted).
REQ-015 In IDLE with any req_i bit high, the arbiter SHALL pick the first requester at or after rr_ptr, with modulo-NUM_MST wrap, and enter OWN on the next edge. Request-to-grant latency is exactly 1 cycle.
REQ-016 In OWN, the arbiter SHALL increment xfer_cnt_o on each accepted transfer, saturating at QUANTUM.
REQ-017 The arbiter SHALL never change the grant in a cycle where the owner request is high and slave_waitreq_i is high (transfer stalled).
REQ-018 Release condition (a): owner req low. The grant SHALL be released in that cycle, effective at the next edge.
REQ-019 Release condition (b): an accepted transfer brings the count to QUANTUM while another req_i bit is high. The grant SHALL be released on that edge.
REQ-020 If QUANTUM is reached and no other master is requesting, the arbiter SHALL keep the owner and reset xfer_cnt_o to 0.
REQ-021 On release, rr_ptr SHALL load (owner index + 1) mod NUM_MST. If any request remains, the arbiter SHALL grant the next winner on the same edge with no IDLE bubble; otherwise it SHALL go to IDLE.
REQ-022 xfer_cnt_o SHALL clear to 0 on every grant change.
REQ-023 port_sel_o and port_nosel_o SHALL be derived only from the registered grant and SHALL be glitch-free with respect to req_i.
REQ-024 Request bits for indices >= NUM_MST do not exist. Any select code >= NUM_MST is unreachable.

Reset
REQ-025 On rst high at a clock edge, the block SHALL enter IDLE: grant_o = 0, port_sel_o = 0, port_nosel_o = 1, xfer_cnt_o = 0, rr_ptr = 0, starve_o = 0, all wait counters = 0.
REQ-026 A reset asserted mid-transfer SHALL drop the grant immediately. Requests present on the first cycle after reset SHALL be arbitrated from rr_ptr = 0.

Configuration
REQ-027 With macro AVALON_ARB_STARVE_EN defined, each master SHALL have an 8-bit wait counter.
- The counter increments while that master requests and is not granted.
- The counter clears when that master is granted or drops its request.
REQ-028 With AVALON_ARB_STARVE_EN defined, when any counter reaches STARVE_LIMIT:
- The owner's next accepted transfer SHALL be treated as quantum-exhausted.
- The starved master, lowest index first on ties, SHALL win ahead of round-robin order.
- starve_o SHALL pulse for one cycle on that grant edge.
REQ-029 Without AVALON_ARB_STARVE_EN, the wait counters SHALL be absent and starve_o SHALL be tied to 0.

Structure
REQ-030 Shared package avalon_bm_pkg SHALL hold the NUM_MST and SEL_W defaults, the state enumeration, and the one-hot-to-index function.
REQ-031 Sub-module avalon_rr_picker SHALL implement the combinational "first set bit at or after pointer, with wrap" search and return a one-hot result plus a valid flag.

Verification
REQ-032 Reset then req_i=5'b00100 -> cycle+1: grant_o=00100, port_sel_o=2, port_nosel_o=0.
REQ-033 req_i=5'b11111, waitreq low, QUANTUM=4 -> grant order 0,1,2,3,4,0, each owner holding exactly 4 accepted transfers, no idle cycles between turns.
REQ-034 Owner 1 mid-transfer with waitreq held high for 10 cycles while 3 requests -> grant stays 1 until waitreq falls and the quantum expires.
REQ-035 Only master 3 requests for 12 transfers -> grant stays 3 and xfer_cnt_o wraps 4->0 three times.
REQ-036 rst pulsed while master 4 is granted -> next cycle grant_o=0 and port_nosel_o=1; with req_i=5'b10001 the next grant is 0.
REQ-037 AVALON_ARB_STARVE_EN defined, STARVE_LIMIT=8, owner 0 stalled by waitreq, master 2 waiting -> after the owner's next accepted transfer, grant=2 and starve_o pulses once.

Source files
------------

// File: rtl/avalon_bm_pkg.sv
// ============================================================================
// Module      : avalon_bm_pkg
// Description : Shared defaults, arbiter state encoding and the one-hot to
//               index helper used by the Avalon bus-matrix arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avalon_bm_pkg;

  localparam int NUM_MST_DEF = 5;
  localparam int SEL_W_DEF   = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // OR-reduction of set-bit positions; exact for one-hot or all-zero input.
  function automatic logic [7:0] onehot_to_idx(input logic [31:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_rr_picker.sv
// ============================================================================
// Module      : avalon_rr_picker
// Description : Combinational first-set-bit search starting at a pointer,
//               wrapping modulo N; returns one-hot winner and valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_rr_picker
  import avalon_bm_pkg::*;
#(
  parameter int N  = NUM_MST_DEF,
  parameter int PW = SEL_W_DEF
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_mask[k] = (k >= int'(i_ptr));
    end
  end

  // Requests at/after the pointer win; otherwise wrap to the lowest index.
  assign w_hi    = i_req & w_mask;
  assign w_sel   = (|w_hi) ? w_hi : i_req;
  assign o_grant = w_sel & (~w_sel + N'(1));
  assign o_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/avalon_wrr_arbiter.sv
// ============================================================================
// Module      : avalon_wrr_arbiter
// Description : Weighted round-robin Avalon slave-port arbiter with a
//               per-turn transfer quantum. Optional starvation promotion is
//               built when macro AVALON_ARB_STARVE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_wrr_arbiter
  import avalon_bm_pkg::*;
#(
  parameter int NUM_MST      = NUM_MST_DEF,
  parameter int SEL_W        = SEL_W_DEF,
  parameter int QUANTUM      = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MST-1:0] req_i,
  input  logic               slave_waitreq_i,
  output logic [NUM_MST-1:0] grant_o,
  output logic [SEL_W-1:0]   port_sel_o,
  output logic               port_nosel_o,
  output logic [3:0]         xfer_cnt_o,
  output logic               starve_o
);

  if ((1 << SEL_W) < NUM_MST || NUM_MST > 32) begin : g_chk_sel
    $error("avalon_wrr_arbiter: SEL_W too small for NUM_MST");
  end
  if (QUANTUM < 1 || QUANTUM > 15) begin : g_chk_quantum
    $error("avalon_wrr_arbiter: QUANTUM out of range 1..15");
  end
  if (STARVE_LIMIT < 2 || STARVE_LIMIT > 255) begin : g_chk_starve
    $error("avalon_wrr_arbiter: STARVE_LIMIT out of range 2..255");
  end

  logic [0:0]         r_state;
  logic [NUM_MST-1:0] r_grant;
  logic [3:0]         r_cnt;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_starve;

  logic [0:0]         w_state_n;
  logic [NUM_MST-1:0] w_grant_n;
  logic [3:0]         w_cnt_n;
  logic [SEL_W-1:0]   w_ptr_n;
  logic               w_starve_n;

  logic               w_owner_req;
  logic               w_accept;
  logic [NUM_MST-1:0] w_others;
  logic [3:0]         w_cnt_inc;
  logic               w_qhit;
  logic               w_release;
  logic [SEL_W-1:0]   w_owner_idx;
  logic [SEL_W-1:0]   w_ptr_after;

  logic [NUM_MST-1:0] w_pick_req;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic [NUM_MST-1:0] w_pick_oh;
  logic               w_pick_valid;

  logic [NUM_MST-1:0] w_starved;
  logic [NUM_MST-1:0] w_starve_oh;
  logic               w_starve_any;
  logic [NUM_MST-1:0] w_cand;

  assign w_owner_req = |(req_i & r_grant);
  assign w_accept    = w_owner_req & ~slave_waitreq_i;
  assign w_others    = req_i & ~r_grant;
  assign w_cnt_inc   = r_cnt + 4'd1;
  assign w_owner_idx = SEL_W'(onehot_to_idx(32'(r_grant)));
  assign w_ptr_after = (w_owner_idx >= SEL_W'(NUM_MST - 1)) ? '0 : w_owner_idx + SEL_W'(1);

  // In IDLE search from the stored pointer; while owning, search the
  // non-owners from just past the owner so the handoff needs no bubble.
  assign w_pick_req = (r_state == ST_IDLE) ? req_i : w_others;
  assign w_pick_ptr = (r_state == ST_IDLE) ? r_ptr : w_ptr_after;

  avalon_rr_picker #(
    .N  (NUM_MST),
    .PW (SEL_W)
  ) u_picker (
    .i_req   (w_pick_req),
    .i_ptr   (w_pick_ptr),
    .o_grant (w_pick_oh),
    .o_valid (w_pick_valid)
  );

`ifdef AVALON_ARB_STARVE_EN
  logic [7:0] r_wait [NUM_MST];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MST; i++) begin
      if (rst || !req_i[i] || r_grant[i]) begin
        r_wait[i] <= '0;
      end else if (r_wait[i] != 8'hFF) begin
        r_wait[i] <= r_wait[i] + 8'd1;
      end
    end
  end

  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      w_starved[i] = w_others[i] & (r_wait[i] >= 8'(STARVE_LIMIT));
    end
  end
`else
  assign w_starved = '0;
`endif

  assign w_starve_any = |w_starved;
  assign w_starve_oh  = w_starved & (~w_starved + NUM_MST'(1));
  assign w_cand       = w_starve_any ? w_starve_oh : w_pick_oh;

  // A pending starvation cuts the owner's turn at its next accepted transfer.
  assign w_qhit    = (w_cnt_inc >= 4'(QUANTUM)) | w_starve_any;
  assign w_release = ~w_owner_req | (w_accept & w_qhit & (|w_others));

  always_comb begin
    w_state_n  = r_state;
    w_grant_n  = r_grant;
    w_cnt_n    = r_cnt;
    w_ptr_n    = r_ptr;
    w_starve_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_n  = ST_OWN;
          w_grant_n  = w_cand;
          w_cnt_n    = '0;
          w_starve_n = w_starve_any;
        end
      end
      default: begin
        if (w_release) begin
          w_ptr_n = w_ptr_after;
          w_cnt_n = '0;
          if (w_pick_valid) begin
            w_grant_n  = w_cand;
            w_starve_n = w_starve_any;
          end else begin
            w_state_n = ST_IDLE;
            w_grant_n = '0;
          end
        end else if (w_accept) begin
          w_cnt_n = w_qhit ? 4'd0 : w_cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_starve <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_cnt    <= w_cnt_n;
      r_ptr    <= w_ptr_n;
      r_starve <= w_starve_n;
    end
  end

  assign grant_o      = r_grant;
  assign port_sel_o   = w_owner_idx;
  assign port_nosel_o = ~|r_grant;
  assign xfer_cnt_o   = r_cnt;
  assign starve_o     = r_starve;

endmodule

`default_nettype wire

// File: tb/tb_avalon_wrr_arbiter.sv
// ============================================================================
// Module      : tb_avalon_wrr_arbiter
// Description : Directed self-checking bench for avalon_wrr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avalon_wrr_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req_i;
  logic       slave_waitreq_i;
  logic [4:0] grant_o;
  logic [2:0] port_sel_o;
  logic       port_nosel_o;
  logic [3:0] xfer_cnt_o;
  logic       starve_o;

  int errors = 0;
  int checks = 0;

  avalon_wrr_arbiter #(
    .NUM_MST      (5),
    .SEL_W        (3),
    .QUANTUM      (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .slave_waitreq_i (slave_waitreq_i),
    .grant_o         (grant_o),
    .port_sel_o      (port_sel_o),
    .port_nosel_o    (port_nosel_o),
    .xfer_cnt_o      (xfer_cnt_o),
    .starve_o        (starve_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = '0;
    slave_waitreq_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = 5'b11111;
    tick();
    tick();
    checks++; if (grant_o !== 5'b00000) begin errors++; $display("FAIL reset_grant got=%b exp=00000", grant_o); end
    checks++; if (port_sel_o !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", port_sel_o); end
    checks++; if (port_nosel_o !== 1'b1) begin errors++; $display("FAIL reset_nosel got=%b exp=1", port_nosel_o); end
    checks++; if (xfer_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt_o); end
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL reset_starve got=%b exp=0", starve_o); end
    rst = 1'b0;
    req_i = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 5'b00100;
    tick();
    checks++; if (grant_o !== 5'b00100) begin errors++; $display("FAIL single_grant got=%b exp=00100", grant_o); end
    checks++; if (port_sel_o !== 3'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", port_sel_o); end
    checks++; if (port_nosel_o !== 1'b0) begin errors++; $display("FAIL single_nosel got=%b exp=0", port_nosel_o); end
    req_i = '0;
    tick();
    checks++; if (grant_o !== 5'b00000) begin errors++; $display("FAIL single_release got=%b exp=00000", grant_o); end
    checks++; if (port_nosel_o !== 1'b1) begin errors++; $display("FAIL single_idle_nosel got=%b exp=1", port_nosel_o); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g;
    do_reset();
    req_i = 5'b11111;
    for (int t = 0; t < 24; t++) begin
      tick();
      exp_g = 5'(1 << ((t / 4) % 5));
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, grant_o, exp_g); end
      checks++; if (xfer_cnt_o !== 4'(t % 4)) begin errors++; $display("FAIL rr_cnt t=%0d got=%0d exp=%0d", t, xfer_cnt_o, t % 4); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_i = 5'b00010;
    tick();
    checks++; if (grant_o !== 5'b00010) begin errors++; $display("FAIL stall_first got=%b exp=00010", grant_o); end
    req_i = 5'b01010;
    tick();
    tick();
    slave_waitreq_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++; if (grant_o !== 5'b00010 || xfer_cnt_o !== 4'd2) begin
        errors++; $display("FAIL stall_hold t=%0d got=%b/%0d exp=00010/2", t, grant_o, xfer_cnt_o);
      end
    end
    slave_waitreq_i = 1'b0;
    tick();
    checks++; if (grant_o !== 5'b00010 || xfer_cnt_o !== 4'd3) begin errors++; $display("FAIL stall_resume got=%b/%0d exp=00010/3", grant_o, xfer_cnt_o); end
    tick();
    checks++; if (grant_o !== 5'b01000 || xfer_cnt_o !== 4'd0) begin errors++; $display("FAIL stall_handoff got=%b/%0d exp=01000/0", grant_o, xfer_cnt_o); end
  endtask

  task automatic test_solo_wrap();
    int wraps;
    logic [3:0] prev;
    do_reset();
    req_i = 5'b01000;
    tick();
    checks++; if (port_sel_o !== 3'd3) begin errors++; $display("FAIL solo_sel got=%0d exp=3", port_sel_o); end
    wraps = 0;
    prev = xfer_cnt_o;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if (grant_o !== 5'b01000 || xfer_cnt_o !== 4'((k + 1) % 4)) begin
        errors++; $display("FAIL solo_cnt k=%0d got=%b/%0d exp=01000/%0d", k, grant_o, xfer_cnt_o, (k + 1) % 4);
      end
      if (prev == 4'd3 && xfer_cnt_o == 4'd0) wraps++;
      prev = xfer_cnt_o;
    end
    checks++; if (wraps !== 3) begin errors++; $display("FAIL solo_wraps got=%0d exp=3", wraps); end
  endtask

  task automatic test_handoff();
    do_reset();
    req_i = 5'b00001;
    tick();
    req_i = 5'b00110;
    tick();
    checks++; if (grant_o !== 5'b00010) begin errors++; $display("FAIL handoff_1 got=%b exp=00010", grant_o); end
    req_i = 5'b00100;
    tick();
    checks++; if (grant_o !== 5'b00100 || xfer_cnt_o !== 4'd0) begin errors++; $display("FAIL handoff_2 got=%b/%0d exp=00100/0", grant_o, xfer_cnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 5'b10000;
    tick();
    checks++; if (port_sel_o !== 3'd4) begin errors++; $display("FAIL rstmid_sel got=%0d exp=4", port_sel_o); end
    tick();
    rst = 1'b1;
    req_i = 5'b10001;
    tick();
    checks++; if (grant_o !== 5'b00000 || port_nosel_o !== 1'b1) begin errors++; $display("FAIL rstmid_drop got=%b/%b exp=00000/1", grant_o, port_nosel_o); end
    checks++; if (xfer_cnt_o !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", xfer_cnt_o); end
    rst = 1'b0;
    tick();
    checks++; if (grant_o !== 5'b00001 || port_sel_o !== 3'd0) begin errors++; $display("FAIL rstmid_regrant got=%b/%0d exp=00001/0", grant_o, port_sel_o); end
    checks++; if (port_nosel_o !== 1'b0 || starve_o !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", port_nosel_o, starve_o); end
  endtask

`ifdef AVALON_ARB_STARVE_EN
  task automatic test_starve();
    do_reset();
    slave_waitreq_i = 1'b1;
    req_i = 5'b00101;
    tick();
    checks++; if (grant_o !== 5'b00001 || starve_o !== 1'b0) begin errors++; $display("FAIL starve_first got=%b/%b exp=00001/0", grant_o, starve_o); end
    for (int t = 0; t < 11; t++) tick();
    checks++; if (grant_o !== 5'b00001) begin errors++; $display("FAIL starve_hold got=%b exp=00001", grant_o); end
    slave_waitreq_i = 1'b0;
    tick();
    checks++; if (grant_o !== 5'b00100 || starve_o !== 1'b1) begin errors++; $display("FAIL starve_promote got=%b/%b exp=00100/1", grant_o, starve_o); end
    tick();
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL starve_pulse got=%b exp=0", starve_o); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_i = '0;
    slave_waitreq_i = 1'b0;
    test_reset();
    test_single();
`ifndef AVALON_ARB_STARVE_EN
    test_round_robin();
    test_stall();
`endif
    test_solo_wrap();
    test_handoff();
    test_reset_mid();
`ifdef AVALON_ARB_STARVE_EN
    test_starve();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
